uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial transmitter that drains bytes from a valid/ready source (normally the dequeue side of the lab FIFO) and shifts each byte out as an asynchronous 8N1 frame on a single line. It is the read-end consumer of the FIFO: it drives the ready signal and transmits one frame per accepted byte. The block sits between the FIFO and the board's UART TX pin and runs entirely in the system clock domain.

## Interface
- CLOCK_FREQ, 125_000_000, system clock frequency in Hz
- BAUD_RATE, 115_200, line rate in bits/s; S = CLOCK_FREQ / BAUD_RATE (integer floor) clock cycles per symbol, S >= 2
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- data_in  input  8  byte to transmit, sampled only on a fire cycle
- data_in_valid  input  1  source has a byte available
- data_in_ready  output  1  transmitter can accept a byte this cycle
- serial_out  output  1  UART line, idle high

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, START, DATA, PARITY (only with UART_TX_PARITY_EN), STOP.
- fire = data_in_valid & data_in_ready; data_in latched into internal shift register on fire.
- data_in_ready = (state == IDLE) & !reset; combinational from state, no dependence on data_in_valid.
- IDLE: serial_out = 1; on fire -> START.
- START: serial_out = 0 for S cycles -> DATA.
- DATA: 8 bits, LSB first, each held S cycles; 3-bit bit counter; after bit 7 -> PARITY if enabled, else STOP.
- PARITY: serial_out = even parity (XOR of the 8 latched bits), S cycles -> STOP.
- STOP: serial_out = 1 for S cycles -> IDLE.
- Symbol counter: ceil(log2(S)) bits, counts 0..S-1, cleared on every state/bit transition; transition occurs when counter == S-1.
- serial_out is a register (no glitches); value depends only on state, bit counter, shift register.
- Valid deasserted or toggling while not ready: ignored, no effect on frame in progress.
- data_in changing after fire: no effect on current frame.

## Timing
- Reset values: serial_out = 1, data_in_ready = 0 while reset high; state IDLE, counters 0.
- First cycle after reset deasserts: data_in_ready = 1.
- Fire in cycle t: serial_out = 0 from cycle t+1 through t+S; data bit i occupies cycles t+1+S(1+i) .. t+S(2+i).
- Without parity: stop bit cycles t+1+9S .. t+10S; IDLE (ready = 1) at t+10S+1. With parity: add S, IDLE at t+11S+1.
- Back-to-back: valid held high gives a new start bit every 10S+1 cycles (11S+1 with parity); exactly one idle-high cycle between frames.
- Reset mid-frame: next cycle serial_out = 1, state IDLE, frame discarded, no retransmission; ready = 1 the cycle after reset drops.
- Fire and reset in same cycle: reset wins, byte not accepted.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state compiled in, frame is 8E1 (11 symbols).
- Undefined: no PARITY state or parity logic, frame is 8N1 (10 symbols).

## Test plan
- Reset behaviour: assert reset 3 cycles with valid = 1 -> serial_out = 1, ready = 0 throughout; ready = 1 first cycle after release, no frame started during reset.
- Single byte, CLOCK_FREQ = 1000, BAUD_RATE = 100 (S = 10), data_in = 0xA5 -> line 0, 1,0,1,0,0,1,0,1, 1, each exactly 10 cycles; ready = 1 at cycle t+101.
- Back-to-back 0x00, 0xFF, 0x55 from FIFO with valid held high -> three frames, start bits 101 cycles apart, decoded bytes match in order, exactly one accepted byte per frame.
- Ready gating: valid pulsed high mid-frame with data_in = 0x3C, then dropped -> no fire, current frame unchanged, 0x3C never transmitted.
- Reset mid-frame: reset during data bit 4 of 0xF0 -> serial_out = 1 next cycle, no stop bit, new 0x12 after release transmitted correctly.
- With UART_TX_PARITY_EN: 0x07 -> parity bit 1; 0x03 -> parity bit 0; frame 110 cycles, next ready at t+111.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// Byte handshake between the FIFO dequeue side (master) and the UART transmitter (slave).
interface uart_transmitter_if;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_in_ready;

   modport master (output data_in, output data_in_valid, input data_in_ready);
   modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter draining a valid/ready byte source; 8E1 when UART_TX_PARITY_EN is defined.
module uart_transmitter #(
   parameter int unsigned CLOCK_FREQ = 125_000_000,
   parameter int unsigned BAUD_RATE  = 115_200
) (
   input  logic              clk,
   input  logic              reset,
   uart_transmitter_if.slave in_if,
   output logic              serial_out
);
   localparam int unsigned S     = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned CNT_W = (S > 1) ? $clog2(S) : 1;
   localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(S - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             serial_out_q, serial_out_d;
   logic             ready, fire, sym_done;

   assign ready               = (state_q == IDLE) & ~reset;
   assign fire                = in_if.data_in_valid & ready;
   assign in_if.data_in_ready = ready;
   assign serial_out          = serial_out_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      sym_done = (cnt_q == SYM_LAST);
      if (state_q != IDLE) cnt_d = sym_done ? '0 : cnt_q + 1'b1;
      case (state_q)
         IDLE: if (fire) begin
            state_d = START;
            shift_d = in_if.data_in;
            cnt_d   = '0;
            bit_d   = '0;
         end
         START: if (sym_done) state_d = DATA;
         // Rotate rather than shift so the byte is intact again for parity.
         DATA: if (sym_done) begin
            shift_d = {shift_q[0], shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
            if (bit_q == 3'd7) state_d = PARITY;
`else
            if (bit_q == 3'd7) state_d = STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (sym_done) state_d = STOP;
`endif
         STOP: if (sym_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Line level is registered from the next-state view so it changes with the state.
      case (state_d)
         START:   serial_out_d = 1'b0;
         DATA:    serial_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  serial_out_d = ^shift_d;
`endif
         default: serial_out_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         serial_out_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         serial_out_q <= serial_out_d;
      end
   end
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at S = 10 cycles/symbol; honours UART_TX_PARITY_EN.
module tb_uart_transmitter;
   localparam int unsigned S = 10;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NSYM = 11;
`else
   localparam int unsigned NSYM = 10;
`endif

   logic clk;
   logic reset;
   logic serial_out;
   int   total;
   int   bad;

   uart_transmitter_if u_if ();

   uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_if      (u_if),
      .serial_out (serial_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line level in cycle t+i of a frame for byte b fired in cycle t.
   function automatic logic exp_bit(input logic [7:0] b, input int unsigned i);
      int unsigned sym;
      sym = (i - 1) / S;
      if (sym == 0) return 1'b0;
      if (sym <= 8) return b[sym-1];
`ifdef UART_TX_PARITY_EN
      if (sym == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Call in a cycle where ready is observed high; fires b now and checks every line cycle.
   task automatic frame(input logic [7:0] b, input bit hold, input bit noise);
      u_if.data_in       = b;
      u_if.data_in_valid = 1'b1;
      for (int unsigned i = 1; i <= NSYM * S; i++) begin
         tick();
         if (!hold && i == 1) begin
            u_if.data_in_valid = 1'b0;
            u_if.data_in       = 8'h3C;
         end
         if (noise) u_if.data_in_valid = (i >= 40 && i < 45);
         chk($sformatf("line_%02h_c%0d", b, i), {7'd0, serial_out}, {7'd0, exp_bit(b, i)});
         chk($sformatf("busy_%02h_c%0d", b, i), {7'd0, u_if.data_in_ready}, 8'd0);
      end
      tick();
      chk($sformatf("rdy_after_%02h", b), {7'd0, u_if.data_in_ready}, 8'd1);
      chk($sformatf("idle_after_%02h", b), {7'd0, serial_out}, 8'd1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      u_if.data_in_valid = 1'b1;
      u_if.data_in       = 8'hAA;

      // Reset held 3 cycles with valid high: idle line, never ready.
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         chk("rst_line", {7'd0, serial_out}, 8'd1);
         chk("rst_rdy", {7'd0, u_if.data_in_ready}, 8'd0);
      end
      reset = 1'b0;
      u_if.data_in_valid = 1'b0;
      tick();
      chk("post_rst_rdy", {7'd0, u_if.data_in_ready}, 8'd1);
      chk("post_rst_line", {7'd0, serial_out}, 8'd1);
      tick();
      chk("no_frame_from_rst", {7'd0, serial_out}, 8'd1);

      // Single byte, data_in changed after fire, then a mid-frame valid pulse with 0x3C.
      frame(8'hA5, 1'b0, 1'b0);
      frame(8'hC3, 1'b0, 1'b1);

      // Back-to-back with valid held high.
      frame(8'h00, 1'b1, 1'b0);
      frame(8'hFF, 1'b1, 1'b0);
      frame(8'h55, 1'b0, 1'b0);

      // Reset during data bit 4 of 0xF0; a valid byte offered during reset is not taken.
      u_if.data_in       = 8'hF0;
      u_if.data_in_valid = 1'b1;
      for (int unsigned i = 1; i <= 55; i++) begin
         tick();
         if (i == 1) u_if.data_in_valid = 1'b0;
         chk($sformatf("f0_line_c%0d", i), {7'd0, serial_out}, {7'd0, exp_bit(8'hF0, i)});
      end
      reset = 1'b1;
      u_if.data_in       = 8'h99;
      u_if.data_in_valid = 1'b1;
      tick();
      chk("midrst_line", {7'd0, serial_out}, 8'd1);
      chk("midrst_rdy", {7'd0, u_if.data_in_ready}, 8'd0);
      tick();
      chk("midrst_rdy2", {7'd0, u_if.data_in_ready}, 8'd0);
      reset = 1'b0;
      u_if.data_in_valid = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         chk("midrst_rel_rdy", {7'd0, u_if.data_in_ready}, 8'd1);
         chk("midrst_rel_line", {7'd0, serial_out}, 8'd1);
      end
      frame(8'h12, 1'b0, 1'b0);

      // Parity boundary bytes (odd and even weight).
      frame(8'h07, 1'b0, 1'b0);
      frame(8'h03, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end
endmodule
